tt_um_jleightcap: RTL and testbench
===================================

// Module: tt_um_jleightcap
// PURPOSE
// - TinyTapeout user tile: 8-bit, 4-entry RPN stack calculator, top level of the tile.
// - Operands enter on ui_in; opcodes are strobed on uio_in.
// - Top-of-stack drives uo_out; status flags drive uio_out[7:5].
// PARAMETERS
// - DEPTH  4  stack entries (fixed; the depth counter is 3 bits wide)
// - WIDTH  8  data width (fixed by the TT pinout)
// PORTS
// - clk      in   1  system clock, rising edge
// - rst_n    in   1  reset, asynchronous, active-low
// - ena      in   1  tile enable; when low, no operation executes and all state holds
// - ui_in    in   8  operand for PUSH
// - uio_in   in   8  [3:0] opcode, [4] execute strobe, [7:5] ignored
// - uo_out   out  8  top of stack; 0 when the stack is empty
// - uio_out  out  8  [7] err (sticky), [6] carry, [5] zero (uo_out==0), [4:0] = 0
// - uio_oe   out  8  constant 8'b1110_0000
// BEHAVIOUR
// - Reset (async, rst_n=0): stack entries=0, depth=0, err=0, carry=0, stb_q=0.
//   Resulting outputs: uo_out=0, uio_out=8'h20 (zero flag set).
// - Strobe edge: stb_q <= uio_in[4] every cycle while ena=1.
//   exec = ena & uio_in[4] & ~stb_q.
//   Exactly one operation per rising edge of the strobe; holding the strobe high does not repeat.
// - Latency: the operation commits at the clock edge where exec=1.
//   uo_out and flags reflect it immediately after that edge.
// - Naming: T = top, S = second entry; binary result = S op T.
//   A binary op pops 2 entries and pushes 1, so depth decreases by 1.
// - Opcodes:
//   0 NOP
//   1 PUSH ui_in
//   2 POP
//   3 ADD    carry = bit 8 of S+T
//   4 SUB    S-T, carry = borrow (S<T)
//   5 AND
//   6 OR
//   7 XOR
//   8 DUP
//   9 SWAP
//   A SHL T  carry = T[7], zero-fill
//   B SHR T  carry = T[0], zero-fill
//   C NOT T
//   D CLR    depth=0, err=0, carry=0; entries zeroed
//   E,F      reserved; act as NOP and do not set err
// - Carry is updated only by ADD, SUB, SHL, SHR and CLR; every other op preserves it.
// - Result width: all results truncate to 8 bits (mod 256).
// - Overflow: PUSH or DUP at depth=4 -> stack unchanged, err <= 1.
// - Underflow:
//   - POP, SHL, SHR, NOT, DUP at depth=0 -> no change, err <= 1.
//   - ADD..XOR, SWAP at depth<2 -> no change, err <= 1.
//   - A faulting op never modifies carry.
// - err is sticky; only CLR or reset clears it. Valid ops still execute while err=1.
// - zero flag is combinational: uio_out[5] = (uo_out == 0), including when empty.
// - ena=0: exec is forced low and stb_q holds; no state changes.
//   A strobe that rises while ena=0 and is still high when ena returns executes once.
// - Reset asserted mid-sequence clears all state immediately; no pending op survives.
// TESTING
// - Reset -> uo_out=0, uio_out=8'h20, uio_oe=8'hE0.
// - PUSH 8'hF0, PUSH 8'h20, ADD -> uo_out=8'h10, carry=1, depth 1.
// - PUSH 5, PUSH 7, SUB -> uo_out=8'hFE, carry=1.
//   Then PUSH 8'hFE, XOR -> uo_out=0, zero=1.
// - 4x PUSH (1,2,3,4), then PUSH 9 -> err=1, uo_out=4.
//   Then POP -> uo_out=3, err stays 1. Then CLR -> uo_out=0, err=0.
// - Hold strobe high 10 cycles with PUSH 8'hAA -> exactly one push.
//   Then SWAP with depth 1 -> err=1, uo_out=8'hAA.
// - Sequence PUSH 8'h81, SHL -> uo_out=8'h02, carry=1.
//   Then SHR -> uo_out=8'h01, carry=0. Then NOT -> 8'hFE.
//   Then ena=0 with a strobe pulse -> no change.

Source files
------------

// File: rtl/tt_um_jleightcap.sv
// TinyTapeout tile: 8-bit, 4-entry RPN stack calculator.
// Entry 0 of the stack array is always the top; pushes and pops shift the whole array.
module tt_um_jleightcap (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int DEPTH = 4;

    localparam logic [3:0] OP_PUSH = 4'h1;
    localparam logic [3:0] OP_POP  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_DUP  = 4'h8;
    localparam logic [3:0] OP_SWAP = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_NOT  = 4'hC;
    localparam logic [3:0] OP_CLR  = 4'hD;

    logic [7:0] r_stk [DEPTH];
    logic [2:0] r_depth;
    logic       r_err;
    logic       r_carry;
    logic       r_stb_q;

    logic [7:0] w_stk_next [DEPTH];
    logic [7:0] w_push_stk [DEPTH];
    logic [7:0] w_pop_stk  [DEPTH];
    logic [2:0] w_depth_next;
    logic       w_err_next;
    logic       w_carry_next;
    logic [7:0] w_push_val;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [3:0] w_opc;
    logic       w_exec;
    logic       w_empty;
    logic       w_full;
    logic       w_lt2;
    logic       w_unused;

    assign w_opc    = uio_in[3:0];
    assign w_exec   = ena & uio_in[4] & ~r_stb_q;
    assign w_empty  = (r_depth == 3'd0);
    assign w_full   = (r_depth == 3'd4);
    assign w_lt2    = (r_depth < 3'd2);
    assign w_unused = &{1'b0, uio_in[7:5]};

    assign w_push_val = (w_opc == OP_DUP) ? r_stk[0] : ui_in;
    assign w_sum      = {1'b0, r_stk[1]} + {1'b0, r_stk[0]};
    assign w_diff     = {1'b0, r_stk[1]} - {1'b0, r_stk[0]};

    // Pre-shifted copies of the stack for push (down) and pop (up, zero-filled).
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_shift
            if (gi == 0) begin : g_top
                assign w_push_stk[gi] = w_push_val;
            end else begin : g_below
                assign w_push_stk[gi] = r_stk[gi-1];
            end
            if (gi == DEPTH - 1) begin : g_bot
                assign w_pop_stk[gi] = 8'h00;
            end else begin : g_above
                assign w_pop_stk[gi] = r_stk[gi+1];
            end
        end
    endgenerate

    always_comb begin
        w_stk_next   = r_stk;
        w_depth_next = r_depth;
        w_err_next   = r_err;
        w_carry_next = r_carry;
        if (w_exec) begin
            case (w_opc)
                OP_PUSH, OP_DUP: begin
                    if (w_full || (w_opc == OP_DUP && w_empty)) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_stk_next   = w_push_stk;
                        w_depth_next = r_depth + 3'd1;
                    end
                end
                OP_POP: begin
                    if (w_empty) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_stk_next   = w_pop_stk;
                        w_depth_next = r_depth - 3'd1;
                    end
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                    if (w_lt2) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_stk_next   = w_pop_stk;
                        w_depth_next = r_depth - 3'd1;
                        case (w_opc)
                            OP_ADD: begin
                                w_stk_next[0] = w_sum[7:0];
                                w_carry_next  = w_sum[8];
                            end
                            OP_SUB: begin
                                w_stk_next[0] = w_diff[7:0];
                                w_carry_next  = w_diff[8];
                            end
                            OP_AND:  w_stk_next[0] = r_stk[1] & r_stk[0];
                            OP_OR:   w_stk_next[0] = r_stk[1] | r_stk[0];
                            default: w_stk_next[0] = r_stk[1] ^ r_stk[0];
                        endcase
                    end
                end
                OP_SWAP: begin
                    if (w_lt2) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_stk_next[0] = r_stk[1];
                        w_stk_next[1] = r_stk[0];
                    end
                end
                OP_SHL, OP_SHR, OP_NOT: begin
                    if (w_empty) begin
                        w_err_next = 1'b1;
                    end else if (w_opc == OP_SHL) begin
                        w_stk_next[0] = {r_stk[0][6:0], 1'b0};
                        w_carry_next  = r_stk[0][7];
                    end else if (w_opc == OP_SHR) begin
                        w_stk_next[0] = {1'b0, r_stk[0][7:1]};
                        w_carry_next  = r_stk[0][0];
                    end else begin
                        w_stk_next[0] = ~r_stk[0];
                    end
                end
                OP_CLR: begin
                    for (int i = 0; i < DEPTH; i++) w_stk_next[i] = 8'h00;
                    w_depth_next = 3'd0;
                    w_err_next   = 1'b0;
                    w_carry_next = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_stk[i] <= 8'h00;
            r_depth <= 3'd0;
            r_err   <= 1'b0;
            r_carry <= 1'b0;
            r_stb_q <= 1'b0;
        end else if (ena) begin
            r_stk   <= w_stk_next;
            r_depth <= w_depth_next;
            r_err   <= w_err_next;
            r_carry <= w_carry_next;
            r_stb_q <= uio_in[4];
        end
    end

    assign uo_out  = w_empty ? 8'h00 : r_stk[0];
    assign uio_out = {r_err, r_carry, (uo_out == 8'h00), 5'b00000};
    assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_jleightcap.sv
// Directed bench for the RPN stack tile; expected outputs go through a scoreboard queue.
module tb_tt_um_jleightcap;
    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b0;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_jleightcap dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    logic [15:0] sb_val[$];
    string       sb_tag[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic expect_out(input string tag, input logic [7:0] euo, input logic [7:0] euio);
        sb_val.push_back({euo, euio});
        sb_tag.push_back(tag);
    endtask

    task automatic check_out();
        logic [15:0] e;
        string       tag;
        n_checks++;
        if (sb_val.size() == 0) begin
            $error("FAIL scoreboard_empty got 0 entries required 1");
            return;
        end
        e   = sb_val.pop_front();
        tag = sb_tag.pop_front();
        assert (uo_out === e[15:8]) n_pass++;
        else $error("FAIL %s uo_out got %h required %h", tag, uo_out, e[15:8]);
        n_checks++;
        assert (uio_out === e[7:0]) n_pass++;
        else $error("FAIL %s uio_out got %h required %h", tag, uio_out, e[7:0]);
        $display("op %-10s uo_out=%h uio_out=%h", tag, uo_out, uio_out);
    endtask

    // One strobed operation: strobe rises at a negedge, result checked at the next negedge.
    task automatic op(input string tag, input logic [3:0] opc, input logic [7:0] d,
                      input logic [7:0] euo, input logic [7:0] euio);
        @(negedge clk);
        ui_in  = d;
        uio_in = {3'b000, 1'b1, opc};
        expect_out(tag, euo, euio);
        @(negedge clk);
        check_out();
        uio_in[4] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2;
        expect_out("reset", 8'h00, 8'h20);
        check_out();
        n_checks++;
        assert (uio_oe === 8'hE0) n_pass++;
        else $error("FAIL uio_oe got %h required %h", uio_oe, 8'hE0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;

        op("push_f0", 4'h1, 8'hF0, 8'hF0, 8'h00);
        op("push_20", 4'h1, 8'h20, 8'h20, 8'h00);
        op("add",     4'h3, 8'h00, 8'h10, 8'h40);
        op("push_5",  4'h1, 8'h05, 8'h05, 8'h40);
        op("push_7",  4'h1, 8'h07, 8'h07, 8'h40);
        op("sub",     4'h4, 8'h00, 8'hFE, 8'h40);
        op("push_fe", 4'h1, 8'hFE, 8'hFE, 8'h40);
        op("xor",     4'h7, 8'h00, 8'h00, 8'h60);

        op("clr",     4'hD, 8'h00, 8'h00, 8'h20);
        op("push_1",  4'h1, 8'h01, 8'h01, 8'h00);
        op("push_2",  4'h1, 8'h02, 8'h02, 8'h00);
        op("push_3",  4'h1, 8'h03, 8'h03, 8'h00);
        op("push_4",  4'h1, 8'h04, 8'h04, 8'h00);
        op("push_ovf", 4'h1, 8'h09, 8'h04, 8'h80);
        op("pop_err", 4'h2, 8'h00, 8'h03, 8'h80);
        op("clr",     4'hD, 8'h00, 8'h00, 8'h20);

        // Strobe held high for 10 cycles must push exactly once.
        @(negedge clk);
        ui_in  = 8'hAA;
        uio_in = 8'h11;
        expect_out("hold_1st", 8'hAA, 8'h00);
        @(negedge clk);
        check_out();
        expect_out("hold_10th", 8'hAA, 8'h00);
        repeat (9) @(negedge clk);
        check_out();
        uio_in[4] = 1'b0;
        @(negedge clk);
        op("swap_udf", 4'h9, 8'h00, 8'hAA, 8'h80);
        op("pop_last", 4'h2, 8'h00, 8'h00, 8'hA0);
        op("clr",     4'hD, 8'h00, 8'h00, 8'h20);

        op("push_81", 4'h1, 8'h81, 8'h81, 8'h00);
        op("shl",     4'hA, 8'h00, 8'h02, 8'h40);
        op("shr",     4'hB, 8'h00, 8'h01, 8'h00);
        op("not",     4'hC, 8'h00, 8'hFE, 8'h00);

        // ena low: a strobe pulse must do nothing.
        @(negedge clk);
        ena    = 1'b0;
        ui_in  = 8'h55;
        uio_in = 8'h11;
        @(negedge clk);
        @(negedge clk);
        uio_in[4] = 1'b0;
        @(negedge clk);
        expect_out("ena_off", 8'hFE, 8'h00);
        check_out();

        // Strobe rising while disabled executes once when ena returns.
        ui_in  = 8'h33;
        uio_in = 8'h11;
        @(negedge clk);
        ena = 1'b1;
        expect_out("ena_back", 8'h33, 8'h00);
        @(negedge clk);
        check_out();
        uio_in[4] = 1'b0;
        @(negedge clk);

        op("clr",     4'hD, 8'h00, 8'h00, 8'h20);
        op("rsvd_e",  4'hE, 8'h00, 8'h00, 8'h20);
        op("push_80", 4'h1, 8'h80, 8'h80, 8'h00);
        op("shl_zero", 4'hA, 8'h00, 8'h00, 8'h60);
        op("pop",     4'h2, 8'h00, 8'h00, 8'h60);
        op("add_udf", 4'h3, 8'h00, 8'h00, 8'hE0);
        op("dup_udf", 4'h8, 8'h00, 8'h00, 8'hE0);
        op("push_c3", 4'h1, 8'hC3, 8'hC3, 8'hC0);
        op("dup",     4'h8, 8'h00, 8'hC3, 8'hC0);
        op("and",     4'h5, 8'h00, 8'hC3, 8'hC0);

        // Asynchronous reset between clock edges clears everything at once.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 8'h00, 8'h20);
        check_out();
        @(negedge clk);
        rst_n = 1'b1;
        op("post_rst_pop", 4'h2, 8'h00, 8'h00, 8'hA0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
